// File: rtl/error_countdown_timer.sv
// error_countdown_timer
//   Timed-recovery companion to the central FSM. Arms a seconds countdown
//   when the FSM enters its calc-error state and returns a one-cycle
//   error_timeout pulse on expiry. Also holds the user-configurable
//   countdown length, written while the FSM sits in its config state.
//
// Ports
//   clk              in   system clock
//   rst              in   asynchronous reset, active-high
//   current_state    in   central FSM state register
//   cfg_sec_in       in   requested countdown length (switches)
//   cfg_load         in   single-cycle confirm pulse
//   error_timeout    out  one-cycle pulse when the countdown expires
//   countdown_active out  high while counting
//   countdown_sec    out  seconds remaining, 0 when idle
//   countdown_blink  out  toggles every half second while active
//   cfg_sec          out  currently configured length
module error_countdown_timer #(
    parameter int unsigned TICK_DIV     = 100000000,
    parameter int unsigned STATE_W      = 4,
    parameter int unsigned ERROR_STATE  = 12,
    parameter int unsigned CONFIG_STATE = 13,
    parameter int unsigned DEFAULT_SEC  = 10,
    parameter int unsigned MIN_SEC      = 5,
    parameter int unsigned MAX_SEC      = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STATE_W-1:0] current_state,
    input  logic [3:0]         cfg_sec_in,
    input  logic               cfg_load,
    output logic               error_timeout,
    output logic               countdown_active,
    output logic [3:0]         countdown_sec,
    output logic               countdown_blink,
    output logic [3:0]         cfg_sec
);

    localparam int unsigned PW = $clog2(TICK_DIV);

    localparam logic [PW-1:0]      PRE_TOP  = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0]      PRE_HALF = PW'(TICK_DIV / 2 - 1);
    localparam logic [STATE_W-1:0] ST_ERR   = STATE_W'(ERROR_STATE);
    localparam logic [STATE_W-1:0] ST_CFG   = STATE_W'(CONFIG_STATE);
    localparam logic [3:0]         SEC_DEF  = 4'(DEFAULT_SEC);
    localparam logic [3:0]         SEC_MIN  = 4'(MIN_SEC);
    localparam logic [3:0]         SEC_MAX  = 4'(MAX_SEC);

    typedef enum logic [1:0] {
        T_IDLE,
        T_RUN,
        T_DONE
    } tstate_t;

    tstate_t            state_q, state_d;
    logic [PW-1:0]      pre_q, pre_d;
    logic [3:0]         sec_q, sec_d;
    logic               active_q, active_d;
    logic               blink_q, blink_d;
    logic               timeout_q, timeout_d;
    logic [3:0]         cfg_q, cfg_d;
    logic [STATE_W-1:0] prev_state_q;

    logic in_error;
    logic entry;

    assign in_error = (current_state == ST_ERR);
    assign entry    = in_error && (prev_state_q != ST_ERR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= T_IDLE;
            pre_q        <= '0;
            sec_q        <= '0;
            active_q     <= 1'b0;
            blink_q      <= 1'b0;
            timeout_q    <= 1'b0;
            cfg_q        <= SEC_DEF;
            prev_state_q <= '0;
        end else begin
            state_q      <= state_d;
            pre_q        <= pre_d;
            sec_q        <= sec_d;
            active_q     <= active_d;
            blink_q      <= blink_d;
            timeout_q    <= timeout_d;
            cfg_q        <= cfg_d;
            prev_state_q <= current_state;
        end
    end

    // Configuration: only honoured in the config state, clamped into range.
    always_comb begin
        cfg_d = cfg_q;
        if (cfg_load && (current_state == ST_CFG)) begin
            if (cfg_sec_in < SEC_MIN)
                cfg_d = SEC_MIN;
            else if (cfg_sec_in > SEC_MAX)
                cfg_d = SEC_MAX;
            else
                cfg_d = cfg_sec_in;
        end
    end

    always_comb begin
        state_d   = state_q;
        pre_d     = pre_q;
        sec_d     = sec_q;
        active_d  = active_q;
        blink_d   = blink_q;
        timeout_d = 1'b0;

        case (state_q)
            T_IDLE: begin
                if (entry) begin
                    sec_d    = cfg_q;
                    pre_d    = '0;
                    active_d = 1'b1;
                    blink_d  = 1'b0;
                    state_d  = T_RUN;
                end
            end

            T_RUN: begin
                // Leaving the error state wins over a coincident expiry tick.
                if (!in_error) begin
                    state_d  = T_IDLE;
                    pre_d    = '0;
                    sec_d    = '0;
                    active_d = 1'b0;
                    blink_d  = 1'b0;
                end else if (pre_q == PRE_TOP) begin
                    pre_d = '0;
                    if (sec_q == 4'd1) begin
                        sec_d     = '0;
                        timeout_d = 1'b1;
                        active_d  = 1'b0;
                        blink_d   = 1'b0;
                        state_d   = T_DONE;
                    end else begin
                        sec_d   = sec_q - 4'd1;
                        blink_d = ~blink_q;
                    end
                end else begin
                    pre_d = pre_q + 1'b1;
                    if (pre_q == PRE_HALF)
                        blink_d = ~blink_q;
                end
            end

            T_DONE: begin
                if (!in_error)
                    state_d = T_IDLE;
            end

            default: begin
                state_d  = T_IDLE;
                pre_d    = '0;
                sec_d    = '0;
                active_d = 1'b0;
                blink_d  = 1'b0;
            end
        endcase
    end

    assign error_timeout    = timeout_q;
    assign countdown_active = active_q;
    assign countdown_sec    = sec_q;
    assign countdown_blink  = blink_q;
    assign cfg_sec          = cfg_q;

endmodule

// File: tb/tb_error_countdown_timer.sv
module tb_error_countdown_timer;

    logic       clk;
    logic       rst;
    logic [3:0] current_state;
    logic [3:0] cfg_sec_in;
    logic       cfg_load;
    logic       error_timeout;
    logic       countdown_active;
    logic [3:0] countdown_sec;
    logic       countdown_blink;
    logic [3:0] cfg_sec;

    int tests = 0;
    int fails = 0;

    error_countdown_timer #(
        .TICK_DIV     (10),
        .STATE_W      (4),
        .ERROR_STATE  (12),
        .CONFIG_STATE (13),
        .DEFAULT_SEC  (10),
        .MIN_SEC      (5),
        .MAX_SEC      (15)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .current_state    (current_state),
        .cfg_sec_in       (cfg_sec_in),
        .cfg_load         (cfg_load),
        .error_timeout    (error_timeout),
        .countdown_active (countdown_active),
        .countdown_sec    (countdown_sec),
        .countdown_blink  (countdown_blink),
        .cfg_sec          (cfg_sec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".timeout"}, 32'(error_timeout), 0);
        check({tag, ".active"}, 32'(countdown_active), 0);
        check({tag, ".sec"}, 32'(countdown_sec), 0);
        check({tag, ".blink"}, 32'(countdown_blink), 0);
    endtask

    task automatic do_cfg(input logic [3:0] val);
        current_state = 4'd13;
        cfg_sec_in    = val;
        cfg_load      = 1'b1;
        tick();
        cfg_load      = 1'b0;
        current_state = 4'd0;
        tick();
    endtask

    initial begin
        rst           = 1'b1;
        current_state = 4'd0;
        cfg_sec_in    = 4'd0;
        cfg_load      = 1'b0;
        #23;
        check_idle("reset");
        check("reset.cfg", 32'(cfg_sec), 10);
        @(negedge clk);
        rst = 1'b0;
        tick();
        tick();
        check_idle("idle0");

        // Full 10-second count with default configuration.
        current_state = 4'd12;
        tick();
        check("t1.load_sec", 32'(countdown_sec), 10);
        check("t1.load_active", 32'(countdown_active), 1);
        check("t1.load_blink", 32'(countdown_blink), 0);
        for (int n = 1; n <= 100; n++) begin
            tick();
            check("t1.timeout", 32'(error_timeout), (n == 100) ? 1 : 0);
            check("t1.active", 32'(countdown_active), (n < 100) ? 1 : 0);
            check("t1.sec", 32'(countdown_sec), 32'(10 - n / 10));
            check("t1.blink", 32'(countdown_blink), (n < 100) ? 32'((n / 5) % 2) : 0);
        end
        for (int n = 0; n < 30; n++) begin
            tick();
            check_idle("t1.hold");
        end
        current_state = 4'd0;
        tick();

        // Configuration: accepted value, then countdown of 7 s.
        do_cfg(4'd7);
        check("cfg7", 32'(cfg_sec), 7);
        current_state = 4'd12;
        tick();
        check("t2.load_sec", 32'(countdown_sec), 7);
        for (int n = 1; n <= 75; n++) begin
            tick();
            check("t2.timeout", 32'(error_timeout), (n == 70) ? 1 : 0);
        end
        current_state = 4'd0;
        tick();

        do_cfg(4'd2);
        check("cfg_clamp_lo", 32'(cfg_sec), 5);
        do_cfg(4'd15);
        check("cfg15", 32'(cfg_sec), 15);
        do_cfg(4'd0);
        check("cfg_clamp_zero", 32'(cfg_sec), 5);
        cfg_sec_in = 4'd9;
        cfg_load   = 1'b1;
        tick();
        cfg_load   = 1'b0;
        tick();
        check("cfg_ignored", 32'(cfg_sec), 5);
        do_cfg(4'd10);
        check("cfg10", 32'(cfg_sec), 10);

        // Early retry after 35 cycles, then re-entry restarts the full count.
        current_state = 4'd12;
        tick();
        for (int n = 1; n <= 35; n++) begin
            tick();
            check("t3.timeout", 32'(error_timeout), 0);
        end
        check("t3.sec35", 32'(countdown_sec), 7);
        current_state = 4'd9;
        tick();
        check_idle("t3.abort");
        current_state = 4'd12;
        tick();
        check("t3.reload_sec", 32'(countdown_sec), 10);
        check("t3.reload_active", 32'(countdown_active), 1);
        for (int n = 1; n <= 100; n++) begin
            tick();
            check("t3.timeout2", 32'(error_timeout), (n == 100) ? 1 : 0);
        end
        current_state = 4'd0;
        tick();

        // Abort on the very cycle of the 1 -> 0 tick.
        current_state = 4'd12;
        tick();
        for (int n = 1; n <= 99; n++) tick();
        check("t4.sec1", 32'(countdown_sec), 1);
        check("t4.pre_timeout", 32'(error_timeout), 0);
        current_state = 4'd9;
        tick();
        check_idle("t4.abort");
        for (int n = 0; n < 5; n++) begin
            tick();
            check("t4.no_pulse", 32'(error_timeout), 0);
        end
        current_state = 4'd12;
        tick();
        check("t4.reentry_sec", 32'(countdown_sec), 10);
        check("t4.reentry_active", 32'(countdown_active), 1);
        current_state = 4'd0;
        tick();

        // Asynchronous reset in mid-count.
        do_cfg(4'd7);
        current_state = 4'd12;
        tick();
        for (int n = 1; n <= 30; n++) tick();
        check("t5.sec4", 32'(countdown_sec), 4);
        #2;
        rst = 1'b1;
        #1;
        check_idle("t5.async");
        check("t5.cfg", 32'(cfg_sec), 10);
        #2;
        rst = 1'b0;
        for (int n = 0; n < 50; n++) begin
            tick();
            check("t5.no_pulse", 32'(error_timeout), 0);
        end
        current_state = 4'd0;
        tick();
        tick();
        check_idle("t5.idle");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
